// File: rtl/axi4_stream_receiver_type_1.sv
// AXI4-Stream traffic sink and checker.
// Drives tready with an active/pause duty pattern. Every accepted transfer is
// compared against the expected stream: incrementing tdata, fixed tid/tdest,
// and tlast at the selected packet/frame/stream boundary. Mismatches are
// collected in a sticky error vector.
module axi4_stream_receiver_type_1 #(
  parameter int    AxiStreamReceiverIfTDataWidth         = 32,
  parameter int    AxiStreamReceiverIfTIdWidth           = 8,
  parameter int    AxiStreamReceiverIfTDestWidth         = 8,
  parameter logic [AxiStreamReceiverIfTIdWidth-1:0]   AxiStreamReceiverIfTId   = 'h11,
  parameter logic [AxiStreamReceiverIfTDestWidth-1:0] AxiStreamReceiverIfTDest = 'hDE,
  parameter logic [AxiStreamReceiverIfTDataWidth-1:0] AxiStreamReceiverIfTDataInitial = '0,
  parameter string AxiStreamReceiverIfReceiverMode       = "SINGLE",
  parameter int    AxiStreamReceiverIfCyclesActive       = 2,
  parameter int    AxiStreamReceiverIfCyclesPause        = 4,
  parameter int    AxiStreamReceiverIfTransfersPerPacket = 2,
  parameter int    AxiStreamReceiverIfPacketsPerFrame    = 2,
  parameter int    AxiStreamReceiverIfFramesPerStream    = 2,
  parameter string AxiStreamReceiverIfTlastFlagTrigger   = "STREAM"
) (
  input  logic                                     clk_s_axis_i,
  input  logic                                     rst_s_axis_ni,
  input  logic                                     s_axis_tvalid_i,
  output logic                                     s_axis_tready_o,
  input  logic [AxiStreamReceiverIfTDataWidth-1:0] s_axis_tdata_i,
  input  logic                                     s_axis_tlast_i,
  input  logic [AxiStreamReceiverIfTIdWidth-1:0]   s_axis_tid_i,
  input  logic [AxiStreamReceiverIfTDestWidth-1:0] s_axis_tdest_i,
  output logic                                     done_o,
  output logic                                     error_o,
  output logic [3:0]                               error_code_o,
  output logic [31:0]                              transfer_count_o
);

  localparam bit IsSingle = (AxiStreamReceiverIfReceiverMode == "SINGLE");
  localparam bit IsPacket = (AxiStreamReceiverIfTlastFlagTrigger == "PACKET");
  localparam bit IsFrame  = (AxiStreamReceiverIfTlastFlagTrigger == "FRAME");

  localparam logic [31:0] XferLast   = 32'(AxiStreamReceiverIfTransfersPerPacket - 1);
  localparam logic [31:0] PktLast    = 32'(AxiStreamReceiverIfPacketsPerFrame - 1);
  localparam logic [31:0] FrmLast    = 32'(AxiStreamReceiverIfFramesPerStream - 1);
  localparam logic [31:0] ActiveLast = 32'(AxiStreamReceiverIfCyclesActive - 1);
  localparam bit          HasPause   = (AxiStreamReceiverIfCyclesPause > 0);
  localparam logic [31:0] PauseLast  = HasPause ? 32'(AxiStreamReceiverIfCyclesPause - 1) : 32'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_PAUSE,
    ST_DONE
  } state_t;

  state_t                                   state_q, state_d;
  logic                                     tready_q, tready_d;
  logic                                     done_q, done_d;
  logic [31:0]                              cycle_cnt_q, cycle_cnt_d;
  logic [31:0]                              xfer_q, xfer_d;
  logic [31:0]                              pkt_q, pkt_d;
  logic [31:0]                              frm_q, frm_d;
  logic [AxiStreamReceiverIfTDataWidth-1:0] exp_data_q, exp_data_d;
  logic [3:0]                               error_q, error_d;
  logic [31:0]                              count_q, count_d;

  logic accept;
  logic xfer_last, pkt_last, frm_last;
  logic stream_end;
  logic exp_last;

  // Decode the stream position, the expected tlast and the handshake.
  always_comb begin
    accept     = s_axis_tvalid_i && tready_q;
    xfer_last  = (xfer_q == XferLast);
    pkt_last   = (pkt_q == PktLast);
    frm_last   = (frm_q == FrmLast);
    stream_end = xfer_last && pkt_last && frm_last;
    if (IsPacket) begin
      exp_last = xfer_last;
    end else if (IsFrame) begin
      exp_last = xfer_last && pkt_last;
    end else begin
      exp_last = stream_end;
    end
  end

  // Next-state logic: tready duty cycle, position counters and checks.
  always_comb begin
    state_d     = state_q;
    tready_d    = tready_q;
    done_d      = done_q;
    cycle_cnt_d = cycle_cnt_q;
    xfer_d      = xfer_q;
    pkt_d       = pkt_q;
    frm_d       = frm_q;
    exp_data_d  = exp_data_q;
    error_d     = error_q;
    count_d     = count_q;

    if (accept) begin
      error_d[0] = error_q[0] | (s_axis_tdata_i != exp_data_q);
      error_d[1] = error_q[1] | (s_axis_tlast_i != exp_last);
      error_d[2] = error_q[2] | (s_axis_tid_i != AxiStreamReceiverIfTId);
      error_d[3] = error_q[3] | (s_axis_tdest_i != AxiStreamReceiverIfTDest);
      exp_data_d = exp_data_q + 1'b1;
      count_d    = count_q + 32'd1;
      if (xfer_last) begin
        xfer_d = 32'd0;
        if (pkt_last) begin
          pkt_d = 32'd0;
          frm_d = frm_last ? 32'd0 : frm_q + 32'd1;
        end else begin
          pkt_d = pkt_q + 32'd1;
        end
      end else begin
        xfer_d = xfer_q + 32'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        state_d     = ST_ACTIVE;
        tready_d    = 1'b1;
        cycle_cnt_d = 32'd0;
      end
      ST_ACTIVE: begin
        if (accept && IsSingle && stream_end) begin
          state_d     = ST_DONE;
          tready_d    = 1'b0;
          done_d      = 1'b1;
          cycle_cnt_d = 32'd0;
        end else if (cycle_cnt_q == ActiveLast) begin
          cycle_cnt_d = 32'd0;
          if (HasPause) begin
            state_d  = ST_PAUSE;
            tready_d = 1'b0;
          end
        end else begin
          cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
      end
      ST_PAUSE: begin
        if (cycle_cnt_q == PauseLast) begin
          state_d     = ST_ACTIVE;
          tready_d    = 1'b1;
          cycle_cnt_d = 32'd0;
        end else begin
          cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
      end
      default: begin
        state_d  = ST_DONE;
        tready_d = 1'b0;
        done_d   = 1'b1;
      end
    endcase
  end

  // State and output registers; reset returns to IDLE with a fresh stream.
  always_ff @(posedge clk_s_axis_i or negedge rst_s_axis_ni) begin
    if (!rst_s_axis_ni) begin
      state_q     <= ST_IDLE;
      tready_q    <= 1'b0;
      done_q      <= 1'b0;
      cycle_cnt_q <= 32'd0;
      xfer_q      <= 32'd0;
      pkt_q       <= 32'd0;
      frm_q       <= 32'd0;
      exp_data_q  <= AxiStreamReceiverIfTDataInitial;
      error_q     <= 4'd0;
      count_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      tready_q    <= tready_d;
      done_q      <= done_d;
      cycle_cnt_q <= cycle_cnt_d;
      xfer_q      <= xfer_d;
      pkt_q       <= pkt_d;
      frm_q       <= frm_d;
      exp_data_q  <= exp_data_d;
      error_q     <= error_d;
      count_q     <= count_d;
    end
  end

  assign s_axis_tready_o  = tready_q;
  assign done_o           = done_q;
  assign error_code_o     = error_q;
  assign error_o          = |error_q;
  assign transfer_count_o = count_q;

endmodule

// File: doc/axi4_stream_receiver_type_1.md
Name: axi4_stream_receiver_type_1

Overview:
AXI4-Stream traffic sink and checker; the responder end for axi4_stream_initiator_type_1 streams in NoC validation setups.
- Drives s_axis_tready with a configurable active/pause duty pattern.
- Checks every accepted transfer against the expected stream: tdata sequence, tid, tdest, and tlast placement at the packet, frame or stream boundary.
- Reports a sticky error vector, a transfer count and stream completion.

Parameters:
AxiStreamReceiverIfTDataWidth, 32, tdata width in bits
AxiStreamReceiverIfTIdWidth, 8, tid width
AxiStreamReceiverIfTDestWidth, 8, tdest width
AxiStreamReceiverIfTId, 'h11, expected tid
AxiStreamReceiverIfTDest, 'hDE, expected tdest
AxiStreamReceiverIfTDataInitial, 0, expected tdata of first transfer
AxiStreamReceiverIfReceiverMode, "SINGLE", "SINGLE" (stop after one stream) or "CONTINUOUS" (wrap, run forever)
AxiStreamReceiverIfCyclesActive, 2, consecutive cycles tready high (>=1)
AxiStreamReceiverIfCyclesPause, 4, consecutive cycles tready low; 0 = always ready
AxiStreamReceiverIfTransfersPerPacket, 2, transfers per packet (>=1)
AxiStreamReceiverIfPacketsPerFrame, 2, packets per frame (>=1)
AxiStreamReceiverIfFramesPerStream, 2, frames per stream (>=1)
AxiStreamReceiverIfTlastFlagTrigger, "STREAM", "PACKET", "FRAME" or "STREAM": boundary where tlast is expected

Ports:
clk_s_axis_i  in  1  clock
rst_s_axis_ni  in  1  reset, asynchronous, active-low
s_axis_tvalid_i  in  1  transmitter drives valid transfer
s_axis_tready_o  out  1  receiver accepts transfer
s_axis_tdata_i  in  TDataWidth  payload
s_axis_tlast_i  in  1  boundary flag
s_axis_tid_i  in  TIdWidth  stream identifier
s_axis_tdest_i  in  TDestWidth  destination
done_o  out  1  SINGLE mode: full stream received
error_o  out  1  sticky OR of error_code_o
error_code_o  out  4  sticky: [0] tdata, [1] tlast, [2] tid, [3] tdest mismatch
transfer_count_o  out  32  accepted transfers since reset, wraps at 2^32

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; all counters 0; expected data = TDataInitial.
- A transfer is accepted on a posedge where tvalid_i && tready_o. No other input is sampled.
- tready_o is a registered output decoded from state; it never depends combinationally on tvalid.
- State machine:
  - IDLE -> ACTIVE on the first edge after reset release. tready_o is 1 from the following cycle.
  - ACTIVE holds tready_o=1. A cycle counter increments on every cycle regardless of tvalid. After CyclesActive cycles, go to PAUSE if CyclesPause>0; otherwise stay in ACTIVE.
  - PAUSE holds tready_o=0 for exactly CyclesPause cycles, then returns to ACTIVE. The cycle counter clears on each state change.
  - DONE (SINGLE only) is entered on the edge that accepts the last transfer of the stream. tready_o=0 and done_o=1 from the next cycle until reset. tvalid held high in DONE is ignored and raises no error.
- Position counters xfer/pkt/frm advance per accepted transfer with nested wrap: xfer wraps at TransfersPerPacket and increments pkt; pkt wraps at PacketsPerFrame and increments frm; frm wraps at FramesPerStream.
- Expected tlast = 1 on the last transfer of the selected boundary and 0 on every other transfer:
  - PACKET: xfer at TransfersPerPacket-1.
  - FRAME: the PACKET condition and pkt at PacketsPerFrame-1.
  - STREAM: the FRAME condition and frm at FramesPerStream-1.
- Expected tdata increments by 1 per accepted transfer, mod 2^TDataWidth. It advances even when a mismatch occurs (no resynchronisation).
  - CONTINUOUS: the sequence keeps incrementing across stream boundaries.
  - SINGLE: the sequence ends at the stream end.
- Checks run on each accepted transfer. A mismatch sets its error_code_o bit on that edge, visible the next cycle. Bits clear only on reset. Multiple bits may set on the same edge.
- transfer_count_o increments on each accepted transfer, including erroneous ones.
- Reset mid-stream clears everything. The next stream is checked from TDataInitial.

Test Plan:
1. Reset, tvalid=0 -> all outputs 0. tready reads 1,1,0,0,0,0,1,1,... starting the second cycle after reset release, with no errors.
2. Source offers 8 transfers, tdata 0..7, tid 0x11, tdest 0xDE, tlast only on the 8th, tvalid held high -> 8 accepts only in tready windows. done_o=1, transfer_count_o=8, error_o=0, tready stays 0.
3. Same as 2, but the 4th transfer carries tdata 0x55 -> error_code_o=4'b0001 after that edge. Remaining transfers match. Final count 8, done_o=1.
4. Same as 2, with tlast also asserted on the 4th transfer -> error_code_o[1]=1 after transfer 4, and no other bits set.
5. Same as 2, with the 2nd transfer carrying tid 0x12 and tdest 0xDF -> error_code_o=4'b1100.
6. Reset asserted after 3 transfers, then a clean 8-transfer stream starting at 0 -> outputs 0 during reset. Final count 8, error_o=0, done_o=1.
